// File: rtl/bcd_display_ctrl.sv
// 16-bit binary (optionally two's complement) to five-digit BCD converter
// driving five active-low seven-segment digits, with a one-deep pending load.
module bcd_display_ctrl #(
  parameter int LZB = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        neg,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_RST   = (LZB != 0) ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] bcd_w_q, bcd_w_d;
  logic [15:0] bin_w_q, bin_w_d;
  logic        sign_q, sign_d;
  logic        pend_q, pend_d;
  logic [15:0] pdin_q, pdin_d;
  logic        psm_q, psm_d;
  logic [19:0] bcd_q, bcd_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic [6:0]  hex_q [5];
  logic [6:0]  hex_d [5];

  logic        start;
  logic [15:0] st_din;
  logic        st_sm;
  logic [19:0] adj;
  logic        unused_din;

  assign unused_din = ^din[31:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_w_q <= '0;
      bin_w_q <= '0;
      sign_q  <= 1'b0;
      pend_q  <= 1'b0;
      pdin_q  <= '0;
      psm_q   <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hex_q[0] <= SEG_ZERO;
      for (int unsigned i = 1; i < 5; i++) hex_q[i] <= HEX_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_w_q <= bcd_w_d;
      bin_w_q <= bin_w_d;
      sign_q  <= sign_d;
      pend_q  <= pend_d;
      pdin_q  <= pdin_d;
      psm_q   <= psm_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < 5; i++) hex_q[i] <= hex_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_w_d = bcd_w_q;
    bin_w_d = bin_w_q;
    sign_d  = sign_q;
    pend_d  = pend_q;
    pdin_d  = pdin_q;
    psm_d   = psm_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    for (int unsigned i = 0; i < 5; i++) hex_d[i] = hex_q[i];
    start  = 1'b0;
    st_din = din[15:0];
    st_sm  = signed_mode;
    adj    = '0;

    case (state_q)
      IDLE: start = load;
      SHIFT: begin
        if (load) begin
          pend_d = 1'b1;
          pdin_d = din[15:0];
          psm_d  = signed_mode;
        end
        for (int unsigned i = 0; i < 5; i++)
          adj[4*i +: 4] = (bcd_w_q[4*i +: 4] >= 4'd5) ? bcd_w_q[4*i +: 4] + 4'd3
                                                       : bcd_w_q[4*i +: 4];
        {bcd_w_d, bin_w_d} = {adj[18:0], bin_w_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        bcd_d    = bcd_w_q;
        neg_d    = sign_q && (bcd_w_q != '0);
        done_d   = 1'b1;
        hex_d[0] = seg7(bcd_w_q[3:0]);
        // A digit is blank when it and every digit above it are zero.
        for (int unsigned i = 1; i < 5; i++)
          hex_d[i] = ((LZB != 0) && ((bcd_w_q >> (4*i)) == '0)) ? SEG_BLANK
                                                              : seg7(bcd_w_q[4*i +: 4]);
        if (load) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end else if (pend_q) begin
          start  = 1'b1;
          st_din = pdin_q;
          st_sm  = psm_q;
          pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      bcd_w_d = '0;
      sign_d  = st_sm && st_din[15];
      bin_w_d = (st_sm && st_din[15]) ? (~st_din + 16'd1) : st_din;
    end
  end

  assign busy = (state_q != IDLE) || pend_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 Parameter: LZB, default 1, blank leading zero digits on hex4..hex1 when 1.
REQ-002 Port: clk  in  1  system clock, all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: load  in  1  strobe, same timing as the display-register write enable; din is sampled when high.
REQ-005 Port: din  in  32  write data; only din[15:0] is used.
REQ-006 Port: signed_mode  in  1  when 1, din[15:0] is two's complement; sampled together with din.
REQ-007 Port: busy  out  1  conversion in progress or pending.
REQ-008 Port: done  out  1  one-cycle pulse when outputs update.
REQ-009 Port: bcd  out  20  five BCD digits of the magnitude; [3:0] is units.
REQ-010 Port: neg  out  1  displayed value is negative.
REQ-011 Ports: hex0..hex4  out  7 each  active-low segments, bit6=g..bit0=a; hex0 is units.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; there are no other states.
REQ-013 IDLE with load=1 at an edge SHALL capture the magnitude and sign of din[15:0], clear the shift counter, and go to SHIFT.
- Magnitude = din[15:0] when signed_mode=0 or din[15]=0; otherwise the 16-bit two's-complement negation.
- 16'h8000 signed gives magnitude 32768.
REQ-014 SHIFT SHALL run a double-dabble step per edge: add 3 to each BCD nibble >= 5, then shift {bcd_work, bin_work} left by one.
- Exactly 16 steps, then go to DONE.
REQ-015 The DONE edge SHALL register bcd, neg and hex0..hex4 from the work registers and pulse done high for the following cycle.
REQ-016 Latency SHALL be 17 edges from the load edge to updated outputs; outputs hold their values between updates.
REQ-017 busy SHALL be high whenever state != IDLE or the pending flag is set.
REQ-018 load while not IDLE SHALL write din/signed_mode into a one-deep pending register and set the pending flag.
- A further load while pending overwrites it (last wins).
REQ-019 Leaving DONE, the next state SHALL be chosen by priority:
- load=1 on that edge starts din directly and clears pending;
- else a set pending flag starts the pending value (cleared);
- else IDLE.
- A restart goes straight to SHIFT, and busy stays high.
REQ-020 Segment encoding SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 With LZB=1, every digit above the most significant non-zero digit SHALL be blank (1111111); hex0 is never blanked.
REQ-022 neg SHALL be 0 whenever the magnitude is 0.

Reset
REQ-023 rst SHALL force, immediately and regardless of clk:
- state IDLE, pending cleared, work registers 0;
- busy=0, done=0, bcd=0, neg=0;
- hex0=1000000, hex4..hex1=1111111 (LZB=1) or 1000000 (LZB=0).
REQ-024 rst during SHIFT or DONE SHALL abort the conversion; no done pulse follows and the aborted value never reaches the outputs.

Verification
REQ-025 Reset: rst pulse, no load -> bcd=0, hex0=1000000, hex1..hex4=1111111, busy=0, done=0.
REQ-026 Unsigned: load din=32'h000000FF, signed_mode=0 -> after 17 edges bcd=20'h00255, hex2=0100100, hex1=0010010, hex0=0010010, hex3/hex4 blank; done high exactly one cycle.
REQ-027 Signed extremes:
- din=16'hFFF6, signed_mode=1 -> bcd=20'h00010, neg=1.
- din=16'h8000 signed -> bcd=20'h32768, neg=1.
- din=16'hFFFF unsigned -> bcd=20'h65535, neg=0.
REQ-028 Pending: load 100, then load 7 and load 42 during SHIFT -> outputs 100, then 42; 7 never appears; busy high continuously for 34 cycles; exactly two done pulses.
REQ-029 Simultaneous: load=1 on the DONE edge with pending set -> the new din is converted; the pending value is discarded.
REQ-030 Mid-operation reset: rst asserted at step 8 of SHIFT -> all outputs at reset values; no done pulse; next load converts normally in 17 edges.
